// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: op codes, flag layout and FSM states.
package alu_pkg;

  localparam int DATA_W = 8;

  // Bit positions of each flag inside the {C,V,N,Z} vector.
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_RSV = 2'b11
  } aluOp_t;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } execState_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Upstream op handshake and downstream result handshake of the execute stage.
interface alu_exec_stage_if;
  import alu_pkg::*;

  logic              inValid;
  logic              inReady;
  aluOp_t            inOp;
  logic [DATA_W-1:0] inFirstArg;
  logic [DATA_W-1:0] inSecondArg;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outResult;
  logic              outWrite;

  modport master (
    output inValid, inOp, inFirstArg, inSecondArg, outReady,
    input  inReady, outValid, outResult, outWrite
  );

  modport slave (
    input  inValid, inOp, inFirstArg, inSecondArg, outReady,
    output inReady, outValid, outResult, outWrite
  );

endinterface

// File: rtl/alu.sv
// Combinational 8-bit add/subtract unit. On subtract, unsignedOverflow is the borrow (set when A < B).
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] firstArg,
  input  logic [DATA_W-1:0] secondArg,
  input  logic              isAdding,
  output logic [DATA_W-1:0] result,
  output logic              unsignedOverflow,
  output logic              overflow,
  output logic              sign,
  output logic              isZero
);

  logic        [DATA_W:0]   wide;
  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic signed [DATA_W-1:0] sr;

  always_comb begin
    if (isAdding) wide = {1'b0, firstArg} + {1'b0, secondArg};
    else          wide = {1'b0, firstArg} - {1'b0, secondArg};
  end

  assign result           = wide[DATA_W-1:0];
  assign unsignedOverflow = wide[DATA_W];

  assign sa = signed'(firstArg);
  assign sb = signed'(secondArg);
  assign sr = signed'(result);

  // Signed overflow: operands that can overflow (same sign for add, opposite for sub)
  // produced a result whose sign differs from operand A.
  assign overflow = (isAdding ? (sa[DATA_W-1] == sb[DATA_W-1]) : (sa[DATA_W-1] != sb[DATA_W-1]))
                    && (sr[DATA_W-1] != sa[DATA_W-1]);
  assign sign     = sr[DATA_W-1];
  assign isZero   = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage around the alu: valid/ready in, one EXEC cycle, result held in DONE.
// Optional macro ALU_CMP_EN: when defined, CMP performs a flags-only subtract; otherwise CMP is a NOP.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 resetN,
  alu_exec_stage_if.slave      bus,
  output logic [3:0]           flags,
  output logic [CNT_W-1:0]     opCount
);

  execState_t        state_q, state_d;
  aluOp_t            op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              wr_q, wr_d;
  flags_t            flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] alu_res;
  flags_t            alu_flags;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : CNT_W'(v + 1'b1);
  endfunction

  alu u_alu (
    .firstArg         (a_q),
    .secondArg        (b_q),
    .isAdding         (op_q == OP_ADD),
    .result           (alu_res),
    .unsignedOverflow (alu_flags.c),
    .overflow         (alu_flags.v),
    .sign             (alu_flags.n),
    .isZero           (alu_flags.z)
  );

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.outReady);
  assign accept   = bus.inValid && in_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    wr_d    = wr_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (bus.outReady) state_d = bus.inValid ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_d = bus.inOp;
      a_d  = bus.inFirstArg;
      b_d  = bus.inSecondArg;
    end

    // Result, flags and count commit on the EXEC->DONE edge.
    if (state_q == EXEC) begin
      cnt_d = sat_inc(cnt_q);
      case (op_q)
        OP_ADD, OP_SUB: begin
          res_d   = alu_res;
          wr_d    = 1'b1;
          flags_d = alu_flags;
        end
`ifdef ALU_CMP_EN
        OP_CMP: begin
          res_d   = alu_res;
          wr_d    = 1'b0;
          flags_d = alu_flags;
        end
`endif
        default: begin
          res_d = a_q;
          wr_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      flags_q <= flags_t'(FLAGS_RST);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.inReady   = in_ready;
  assign bus.outValid  = (state_q == DONE);
  assign bus.outResult = res_q;
  assign bus.outWrite  = wr_q;
  assign flags         = flags_q;
  assign opCount       = cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and randomized bench for alu_exec_stage against an arithmetic reference model.
module tb_alu_exec_stage;
  import alu_pkg::*;

  localparam int         CNT_W     = 16;
  localparam logic [3:0] FLAGS_RST = 4'b0000;

  logic             clk = 1'b0;
  logic             resetN;
  logic [3:0]       flags;
  logic [CNT_W-1:0] opCount;

  alu_exec_stage_if bus ();

  alu_exec_stage #(.CNT_W(CNT_W), .FLAGS_RST(FLAGS_RST)) dut (
    .clk     (clk),
    .resetN  (resetN),
    .bus     (bus),
    .flags   (flags),
    .opCount (opCount)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] flags_m;
  int         cnt_m;
  logic [7:0] res_m;
  logic       wr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, applied when an op completes.
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int   ua, ub, sa, sb, u, s;
    logic arith, sub;
    ua    = int'(a);
    ub    = int'(b);
    sa    = int'($signed(a));
    sb    = int'($signed(b));
    arith = (op == 2'd0) || (op == 2'd1);
`ifdef ALU_CMP_EN
    if (op == 2'd2) arith = 1'b1;
`endif
    sub = (op != 2'd0);
    if (arith) begin
      u       = sub ? ua - ub : ua + ub;
      s       = sub ? sa - sb : sa + sb;
      res_m   = u[7:0];
      flags_m = {sub ? (ua < ub) : (u > 255), (s > 127) || (s < -128), res_m[7], res_m == 8'd0};
      wr_m    = (op != 2'd2);
    end else begin
      res_m = a;
      wr_m  = 1'b0;
    end
    if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_valid"}, 32'(bus.outValid), 1);
    chk({tag, "_res"},   32'(bus.outResult), 32'(res_m));
    chk({tag, "_wr"},    32'(bus.outWrite), 32'(wr_m));
    chk({tag, "_flags"}, 32'(flags), 32'(flags_m));
    chk({tag, "_cnt"},   32'(opCount), 32'(cnt_m));
  endtask

  // Called at a negedge; returns at the negedge where the result is in DONE.
  task automatic send(input string tag, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.inValid     = 1'b1;
    bus.inOp        = aluOp_t'(op);
    bus.inFirstArg  = a;
    bus.inSecondArg = b;
    #1 chk({tag, "_inready"}, 32'(bus.inReady), 1);
    @(posedge clk);
    model(op, a, b);
    @(negedge clk);
    bus.inValid = 1'b0;
    chk({tag, "_exec_valid"}, 32'(bus.outValid), 0);
    @(negedge clk);
    check_done(tag);
  endtask

  task automatic stall(input int k);
    bus.outReady = 1'b0;
    repeat (k) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.outValid), 1);
      chk("stall_res", 32'(bus.outResult), 32'(res_m));
      chk("stall_inready", 32'(bus.inReady), 0);
    end
    bus.outReady = 1'b1;
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] a, b;
    resetN          = 1'b0;
    bus.inValid     = 1'b0;
    bus.inOp        = OP_ADD;
    bus.inFirstArg  = '0;
    bus.inSecondArg = '0;
    bus.outReady    = 1'b1;
    flags_m         = FLAGS_RST;
    cnt_m           = 0;
    res_m           = '0;
    wr_m            = 1'b0;

    #1;
    chk("rst_valid", 32'(bus.outValid), 0);
    chk("rst_res", 32'(bus.outResult), 0);
    chk("rst_wr", 32'(bus.outWrite), 0);
    chk("rst_flags", 32'(flags), 32'(FLAGS_RST));
    chk("rst_cnt", 32'(opCount), 0);
    chk("rst_inready", 32'(bus.inReady), 1);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    send("add5_25", 2'd0, 8'd5, 8'd25);
    chk("add5_25_const", 32'({bus.outResult, flags, bus.outWrite}), 32'({8'd30, 4'b0000, 1'b1}));
    chk("add5_25_cnt1", 32'(opCount), 1);

    send("sub5_25", 2'd1, 8'd5, 8'd25);
    chk("sub5_25_const", 32'({bus.outResult, flags}), 32'({8'hEC, 4'b1010}));

    send("add127_1", 2'd0, 8'd127, 8'd1);
    chk("add127_1_const", 32'({bus.outResult, flags}), 32'({8'd128, 4'b0110}));

    send("add255_1", 2'd0, 8'd255, 8'd1);
    chk("add255_1_const", 32'({bus.outResult, flags}), 32'({8'd0, 4'b1001}));

    // Stall in DONE with a new op waiting, then release both on the same edge.
    send("stall_op", 2'd1, 8'd200, 8'd13);
    bus.outReady    = 1'b0;
    bus.inValid     = 1'b1;
    bus.inOp        = OP_ADD;
    bus.inFirstArg  = 8'd40;
    bus.inSecondArg = 8'd2;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.outValid), 1);
      chk("hold_res", 32'(bus.outResult), 32'(res_m));
      chk("hold_wr", 32'(bus.outWrite), 32'(wr_m));
      chk("hold_inready", 32'(bus.inReady), 0);
    end
    bus.outReady = 1'b1;
    send("b2b_add", 2'd0, 8'd40, 8'd2);
    chk("b2b_add_const", 32'(bus.outResult), 42);

    send("cmp9_9", 2'd2, 8'd9, 8'd9);
`ifdef ALU_CMP_EN
    chk("cmp9_9_z", 32'({flags[FLAG_Z], bus.outWrite}), 32'({1'b1, 1'b0}));
`else
    chk("cmp9_9_nop", 32'({bus.outResult, bus.outWrite}), 32'({8'd9, 1'b0}));
`endif

    send("nop", 2'd3, 8'h5A, 8'h11);
    chk("nop_const", 32'({bus.outResult, bus.outWrite}), 32'({8'h5A, 1'b0}));

    // Reset while EXEC: the in-flight op must vanish.
    @(negedge clk);
    bus.inValid     = 1'b1;
    bus.inOp        = OP_ADD;
    bus.inFirstArg  = 8'd3;
    bus.inSecondArg = 8'd4;
    @(negedge clk);
    bus.inValid = 1'b0;
    resetN      = 1'b0;
    flags_m     = FLAGS_RST;
    cnt_m       = 0;
    #1;
    chk("midrst_valid", 32'(bus.outValid), 0);
    chk("midrst_flags", 32'(flags), 32'(FLAGS_RST));
    chk("midrst_cnt", 32'(opCount), 0);
    chk("midrst_res", 32'(bus.outResult), 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 32'(bus.outValid), 0);
    chk("postrst_inready", 32'(bus.inReady), 1);
    send("postrst_sub", 2'd1, 8'd100, 8'd1);
    chk("postrst_cnt1", 32'(opCount), 1);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = 8'($urandom);
      send("rnd", op, a, b);
      stall($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("rnd_idle_valid", 32'(bus.outValid), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
